// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage behind the asynchronous FIFO.
// Issues FIFO reads against credit, absorbs the one-cycle RAM read
// latency in a two-entry skid buffer and presents a valid/ready stream.
//
// Handshake: a word moves on the stream when m_valid & m_ready are both
// high at a rising edge of rclk. m_valid is a function of registered
// state only; once raised, m_valid and m_data hold until that transfer.
module fifo_rd_stream #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic [1:0]        occ;
    logic              infl;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;

    logic              pop;
    logic              push;
    logic [2:0]        credit_used;
    logic [2:0]        occ_sum;
    logic [1:0]        occ_next;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign level   = occ;

    // Credit check: a read may issue only if the word it returns will fit
    // after this cycle's pop; reset holds the read enable low.
    always_comb begin
        pop         = m_valid & m_ready;
        push        = infl;
        credit_used = {1'b0, occ} + {2'b00, infl};
        fifo_ren    = ~rrst & ~fifo_empty & (credit_used < (3'd2 + {2'b00, pop}));
        occ_sum     = credit_used - {2'b00, pop};
        occ_next    = occ_sum[1:0];
    end

    // Occupancy and in-flight tracking; a read issued now lands next cycle.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ  <= 2'd0;
            infl <= 1'b0;
        end else begin
            occ  <= occ_next;
            infl <= fifo_ren;
        end
    end

    // Skid buffer data movement; push with occ = 2 is excluded by credit.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            head <= '0;
            tail <= '0;
        end else if (push && !pop) begin
            if (occ == 2'd0) begin
                head <= fifo_rdata;
            end else begin
                tail <= fifo_rdata;
            end
        end else if (pop && !push) begin
            head <= tail;
        end else if (push && pop) begin
            head <= fifo_rdata;
        end
    end

    // Completed-transfer counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: bench for fifo_rd_stream with a behavioural FIFO
// model, a scoreboard queue filled at write time and a monitor that pops
// and compares on every stream transfer.
module tb_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       fifo_empty;
    logic       fifo_ren;
    logic [2:0] fifo_rdata;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] m_data;
    logic [1:0] level;
    logic [7:0] xfer_cnt;

    logic [2:0] mem[$];
    logic [2:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ren_cnt = 0;
    logic       last_ren = 1'b0;
    int         total = 0;

    fifo_rd_stream #(.DATA_W(3), .CNT_W(8)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .xfer_cnt   (xfer_cnt)
    );

    // clock / timeout
    always #5 rclk = ~rclk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // FIFO read-side model: a read at an edge returns data 1 ns later;
    // empty reflects all reads up to and including that edge.
    initial begin
        logic ren_s;
        forever begin
            @(posedge rclk);
            ren_s = fifo_ren;
            #1;
            last_ren = ren_s;
            if (ren_s) begin
                ren_cnt++;
                if (mem.size() == 0) begin
                    n_err++;
                    $display("FAIL over_read: got read of empty FIFO expected none");
                end else begin
                    fifo_rdata = mem.pop_front();
                end
            end
            fifo_empty = (mem.size() == 0);
        end
    end

    // monitor / scoreboard
    initial begin
        logic       prev_stall;
        logic [2:0] prev_data;
        logic [2:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(posedge rclk);
            #8;
            if (rrst) begin
                prev_stall = 1'b0;
            end else begin
                n_cmp++;
                if (fifo_ren && fifo_empty) begin
                    n_err++;
                    $display("FAIL ren_vs_empty: got ren=1 empty=1 expected ren=0");
                end
                n_cmp++;
                if (level > 2'd2) begin
                    n_err++;
                    $display("FAIL level_max: got %0d expected <=2", level);
                end
                if (prev_stall) begin
                    n_cmp++;
                    if (!m_valid || m_data !== prev_data) begin
                        n_err++;
                        $display("FAIL hold: got valid=%0d data=%0d expected valid=1 data=%0d",
                                 m_valid, m_data, prev_data);
                    end
                end
                if (m_valid && m_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL stream_data: got %0d expected no transfer", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data !== e) begin
                            n_err++;
                            $display("FAIL stream_data: got %0d expected %0d", m_data, e);
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [2:0] w);
        mem.push_back(w);
        exp_q.push_back(w);
        total++;
    endtask

    task automatic drain();
        int  t;
        bit  ok;
        t  = 0;
        ok = 1'b0;
        while (t < 3000 && !ok) begin
            tick();
            #5;
            if (exp_q.size() == 0 && !m_valid) ok = 1'b1;
            t++;
        end
        chk("drain_done", int'(ok), 1);
    endtask

    task automatic mid_reset(input int lvl);
        bit found;
        m_ready = 1'b0;
        push_word(3'd2);
        push_word(3'd7);
        push_word(3'd1);
        push_word(3'd4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (int'(level) == lvl) found = 1'b1;
        end
        chk("mid_level_reached", int'(found), 1);
        chk("mid_infl", int'(last_ren), (lvl == 1) ? 1 : 0);
        rrst = 1'b1;
        mem.delete();
        exp_q.delete();
        total = 0;
        tick();
        #5;
        chk("mid_rst_valid", int'(m_valid), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_ren", int'(fifo_ren), 0);
        chk("mid_rst_xfer", int'(xfer_cnt), 0);
        tick();
        rrst = 1'b0;
        #5;
        chk("mid_post_valid", int'(m_valid), 0);
        chk("mid_post_level", int'(level), 0);
    endtask

    // stimulus
    initial begin
        int base;
        int nw;
        rrst       = 1'b1;
        m_ready    = 1'b1;
        fifo_rdata = '0;
        for (int i = 1; i <= 7; i++) push_word(3'(i));
        fifo_empty = 1'b0;

        // reset held with a non-empty FIFO
        repeat (3) begin
            tick();
            #5;
            chk("rst_ren", int'(fifo_ren), 0);
            chk("rst_valid", int'(m_valid), 0);
            chk("rst_level", int'(level), 0);
            chk("rst_xfer", int'(xfer_cnt), 0);
        end
        tick();
        rrst = 1'b0;
        #5;
        chk("rst_no_reads", ren_cnt, 0);
        chk("first_ren", int'(fifo_ren), 1);

        // streaming 1..7: valid from two cycles after the first read
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                tick();
                #5;
            end
            chk("stream_valid", int'(m_valid), (k >= 2 && k <= 8) ? 1 : 0);
        end
        chk("stream_xfer", int'(xfer_cnt), 7);

        // backpressure: 5 words, ready low for 10 cycles
        tick();
        m_ready = 1'b0;
        base = ren_cnt;
        push_word(3'd3);
        push_word(3'd5);
        push_word(3'd2);
        push_word(3'd6);
        push_word(3'd4);
        repeat (10) tick();
        chk("bp_reads", ren_cnt - base, 2);
        chk("bp_level", int'(level), 2);
        chk("bp_valid", int'(m_valid), 1);
        chk("bp_head", int'(m_data), 3);
        m_ready = 1'b1;
        drain();
        chk("bp_xfer", int'(xfer_cnt), 12);

        // empty edge: a single word
        tick();
        base = ren_cnt;
        push_word(3'd5);
        repeat (6) tick();
        chk("edge_reads", ren_cnt - base, 1);
        chk("edge_valid", int'(m_valid), 0);
        chk("edge_xfer", int'(xfer_cnt), 13);

        // random stall with random writes
        nw = 0;
        while (nw < 1000) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                push_word(3'($urandom_range(0, 7)));
                nw++;
            end
        end
        tick();
        m_ready = 1'b1;
        drain();
        chk("rand_xfer", int'(xfer_cnt), 245);

        // mid-operation reset: with a read in flight, then with a full buffer
        tick();
        mid_reset(1);
        mid_reset(2);

        // counter wrap
        m_ready = 1'b1;
        for (int i = 0; i < 255; i++) push_word(3'(i));
        drain();
        chk("wrap_255", int'(xfer_cnt), 255);
        push_word(3'd6);
        drain();
        chk("wrap_0", int'(xfer_cnt), 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
